// File: rtl/s_term_pipe_switch_matrix.sv
// South-terminal switch matrix: per-channel pass-through, 1- or 2-stage register, or tie-zero; modes loaded serially and committed atomically.
// Latency: 0/1/2 cycles per channel according to its mode. Backpressure: none, every channel streams each cycle.
// Optional S_TERM_CFG_READBACK_EN adds ConfigOut (daisy-chain) and ConfigCnt (bit counter) outputs.
module s_term_pipe_switch_matrix #(
    parameter int         NUM_CH       = 12,
    parameter int         CH_W         = 1,
    parameter logic [1:0] DEFAULT_MODE = 2'b00
) (
    input  logic                           UserCLK,
    input  logic                           RESETn,
    input  logic [NUM_CH*CH_W-1:0]         from_S,
    output logic [NUM_CH*CH_W-1:0]         to_N,
    input  logic                           ConfigData,
    input  logic                           ConfigEn,
    input  logic                           ConfigLatch,
`ifdef S_TERM_CFG_READBACK_EN
    output logic                           ConfigOut,
    output logic [$clog2(2*NUM_CH+2)-1:0]  ConfigCnt,
`endif
    output logic                           ConfigErr
);

    localparam int W     = NUM_CH * CH_W;
    localparam int N2    = 2 * NUM_CH;
    localparam int CNT_W = $clog2(N2 + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N2);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(N2 + 1);

    logic [N2-1:0]    sr_q, sr_d;
    logic [N2-1:0]    act_q, act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [W-1:0]     stage1_q, stage1_d;
    logic [W-1:0]     stage2_q, stage2_d;

    always_comb begin
        sr_d     = sr_q;
        act_d    = act_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        stage1_d = from_S;
        stage2_d = stage1_q;
        // A shift always wins over a simultaneous latch request.
        if (ConfigEn) begin
            sr_d = {sr_q[N2-2:0], ConfigData};
            if (cnt_q != CNT_OVER) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (ConfigLatch) begin
            cnt_d = '0;
            if (cnt_q == CNT_FULL) begin
                act_d = sr_q;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge UserCLK or negedge RESETn) begin
        if (!RESETn) begin
            sr_q     <= '0;
            act_q    <= {NUM_CH{DEFAULT_MODE}};
            cnt_q    <= '0;
            err_q    <= 1'b0;
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            sr_q     <= sr_d;
            act_q    <= act_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    // Mode switches use whatever the pipeline already holds; no flush.
    always_comb begin
        to_N = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (act_q[2*i +: 2])
                2'b00:   to_N[i*CH_W +: CH_W] = from_S[i*CH_W +: CH_W];
                2'b01:   to_N[i*CH_W +: CH_W] = stage1_q[i*CH_W +: CH_W];
                2'b10:   to_N[i*CH_W +: CH_W] = stage2_q[i*CH_W +: CH_W];
                default: to_N[i*CH_W +: CH_W] = '0;
            endcase
        end
    end

    assign ConfigErr = err_q;

`ifdef S_TERM_CFG_READBACK_EN
    assign ConfigOut = sr_q[N2-1];
    assign ConfigCnt = cnt_q;
`endif

endmodule

// File: tb/tb_s_term_pipe_switch_matrix.sv
// Randomised bench for s_term_pipe_switch_matrix against a queue/array reference model.
module tb_s_term_pipe_switch_matrix;
    localparam int N = 12;

    logic         UserCLK = 1'b0;
    logic         RESETn;
    logic [N-1:0] from_S;
    logic [N-1:0] to_N;
    logic         ConfigData, ConfigEn, ConfigLatch;
    logic         ConfigErr;
`ifdef S_TERM_CFG_READBACK_EN
    logic         ConfigOut;
    logic [4:0]   ConfigCnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: bits in shift order, counter, sticky error, per-channel mode, input history.
    logic         sr_bits[$];
    int           mcnt;
    logic         merr;
    int           mode[N];
    logic [N-1:0] p1, p2;

    s_term_pipe_switch_matrix #(.NUM_CH(N), .CH_W(1), .DEFAULT_MODE(2'b00)) dut (
        .UserCLK     (UserCLK),
        .RESETn      (RESETn),
        .from_S      (from_S),
        .to_N        (to_N),
        .ConfigData  (ConfigData),
        .ConfigEn    (ConfigEn),
        .ConfigLatch (ConfigLatch),
`ifdef S_TERM_CFG_READBACK_EN
        .ConfigOut   (ConfigOut),
        .ConfigCnt   (ConfigCnt),
`endif
        .ConfigErr   (ConfigErr)
    );

    always #5 UserCLK = ~UserCLK;

    task automatic model_reset();
        sr_bits.delete();
        for (int k = 0; k < 2*N; k++) sr_bits.push_back(1'b0);
        mcnt = 0;
        merr = 1'b0;
        for (int i = 0; i < N; i++) mode[i] = 0;
        p1 = '0;
        p2 = '0;
    endtask

    // sr_bits[$] is the newest bit (SR[0]); sr_bits[0] is the oldest (SR[2N-1]).
    task automatic model_clk();
        p2 = p1;
        p1 = from_S;
        if (ConfigEn) begin
            sr_bits.push_back(ConfigData);
            void'(sr_bits.pop_front());
            if (mcnt < 2*N+1) mcnt++;
        end else if (ConfigLatch) begin
            if (mcnt == 2*N) begin
                for (int i = 0; i < N; i++)
                    mode[i] = 2*int'(sr_bits[2*N-1-(2*i+1)]) + int'(sr_bits[2*N-1-2*i]);
                merr = 1'b0;
            end else begin
                merr = 1'b1;
            end
            mcnt = 0;
        end
    endtask

    function automatic logic [N-1:0] exp_to_n();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            case (mode[i])
                0:       r[i] = from_S[i];
                1:       r[i] = p1[i];
                2:       r[i] = p2[i];
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    // Drive one cycle of controls, clock it into the model, then present fresh random data.
    task automatic tick(input logic en, input logic d, input logic lat);
        ConfigEn    = en;
        ConfigData  = d;
        ConfigLatch = lat;
        @(posedge UserCLK);
        model_clk();
        #1;
        ConfigEn    = 1'b0;
        ConfigData  = 1'b0;
        ConfigLatch = 1'b0;
        from_S      = N'($urandom);
        #1;
    endtask

    task automatic load(input logic [31:0] bits, input int nbits);
        for (int k = nbits - 1; k >= 0; k--) tick(1'b1, bits[k], 1'b0);
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        ConfigEn = 1'b0; ConfigData = 1'b0; ConfigLatch = 1'b0;
        from_S = '0;
        model_reset();
        #12;
        from_S = 12'hA5C;
        #1;
        checks++;
        if (to_N !== 12'hA5C) begin failures++; $display("FAIL reset_pass: to_N=%h want a5c", to_N); end
        checks++;
        if (ConfigErr !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", ConfigErr); end
`ifdef S_TERM_CFG_READBACK_EN
        checks++;
        if (ConfigCnt !== 5'd0 || ConfigOut !== 1'b0) begin
            failures++; $display("FAIL reset_readback: cnt=%0d out=%b want 0/0", ConfigCnt, ConfigOut);
        end
`endif
        @(negedge UserCLK);
        RESETn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if (to_N !== from_S) begin failures++; $display("FAIL default_pass: to_N=%h want %h", to_N, from_S); end
        end
    endtask

    task automatic test_pipe_modes();
        load(32'h0000_0009, 24);
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (ConfigErr !== 1'b0) begin failures++; $display("FAIL pipe_commit_err: got %b want 0", ConfigErr); end
        for (int k = 0; k < 16; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if (to_N !== exp_to_n()) begin failures++; $display("FAIL pipe_modes: to_N=%h want %h", to_N, exp_to_n()); end
        end
        checks++;
        if (to_N[11:2] !== from_S[11:2] || to_N[0] !== p1[0] || to_N[1] !== p2[1]) begin
            failures++; $display("FAIL pipe_lags: to_N=%h from_S=%h p1=%h p2=%h", to_N, from_S, p1, p2);
        end
    endtask

    task automatic test_short_load();
        load($urandom, 23);
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (ConfigErr !== 1'b1) begin failures++; $display("FAIL short_err: got %b want 1", ConfigErr); end
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if (to_N !== exp_to_n()) begin failures++; $display("FAIL short_map_kept: to_N=%h want %h", to_N, exp_to_n()); end
        end
        load($urandom, 24);
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (ConfigErr !== 1'b0) begin failures++; $display("FAIL short_recover_err: got %b want 0", ConfigErr); end
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if (to_N !== exp_to_n() || ConfigErr !== merr) begin
                failures++; $display("FAIL short_new_map: to_N=%h want %h err=%b", to_N, exp_to_n(), ConfigErr);
            end
        end
    endtask

    task automatic test_over();
        load($urandom, 25);
`ifdef S_TERM_CFG_READBACK_EN
        checks++;
        if (ConfigCnt !== 5'd25 || ConfigOut !== sr_bits[0]) begin
            failures++; $display("FAIL over_sat: cnt=%0d out=%b want 25/%b", ConfigCnt, ConfigOut, sr_bits[0]);
        end
`endif
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (ConfigErr !== 1'b1) begin failures++; $display("FAIL over_err: got %b want 1", ConfigErr); end
`ifdef S_TERM_CFG_READBACK_EN
        checks++;
        if (ConfigCnt !== 5'd0) begin failures++; $display("FAIL over_cnt: got %0d want 0", ConfigCnt); end
`endif
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if (to_N !== exp_to_n()) begin failures++; $display("FAIL over_map_kept: to_N=%h want %h", to_N, exp_to_n()); end
        end
        load($urandom, 24);
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (ConfigErr !== 1'b0) begin failures++; $display("FAIL over_recover: got %b want 0", ConfigErr); end
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if (to_N !== exp_to_n()) begin failures++; $display("FAIL over_new_map: to_N=%h want %h", to_N, exp_to_n()); end
        end
    endtask

    task automatic test_tie_zero_reset();
        load(32'h00FF_FFFF, 24);
        tick(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if (to_N !== 12'h000) begin failures++; $display("FAIL tie_zero: to_N=%h want 000", to_N); end
        end
        load($urandom, 10);
        RESETn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (to_N !== from_S || ConfigErr !== 1'b0) begin
            failures++; $display("FAIL mid_reset: to_N=%h want %h err=%b", to_N, from_S, ConfigErr);
        end
        from_S = N'($urandom);
        #1;
        checks++;
        if (to_N !== from_S) begin failures++; $display("FAIL in_reset_stream: to_N=%h want %h", to_N, from_S); end
`ifdef S_TERM_CFG_READBACK_EN
        checks++;
        if (ConfigCnt !== 5'd0) begin failures++; $display("FAIL mid_reset_cnt: got %0d want 0", ConfigCnt); end
`endif
        @(negedge UserCLK);
        RESETn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if (to_N !== exp_to_n()) begin failures++; $display("FAIL post_reset: to_N=%h want %h", to_N, exp_to_n()); end
        end
    endtask

    task automatic test_en_latch_together();
        logic [31:0] map;
        map = $urandom;
        load($urandom, 5);
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (ConfigErr !== 1'b1) begin failures++; $display("FAIL both_pre_err: got %b want 1", ConfigErr); end
        load(map >> 1, 23);
        tick(1'b1, map[0], 1'b1);
        checks++;
        if (ConfigErr !== 1'b1) begin failures++; $display("FAIL both_err_kept: got %b want 1", ConfigErr); end
`ifdef S_TERM_CFG_READBACK_EN
        checks++;
        if (ConfigCnt !== 5'd24) begin failures++; $display("FAIL both_cnt: got %0d want 24", ConfigCnt); end
`endif
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (ConfigErr !== 1'b0) begin failures++; $display("FAIL both_commit: got %b want 0", ConfigErr); end
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if (to_N !== exp_to_n()) begin failures++; $display("FAIL both_map: to_N=%h want %h", to_N, exp_to_n()); end
        end
    endtask

    initial begin
        test_reset();
        test_pipe_modes();
        test_short_load();
        test_over();
        test_tie_zero_reset();
        test_en_latch_together();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/s_term_pipe_switch_matrix.md
Name: s_term_pipe_switch_matrix

Overview:
- Parametrised south-terminal switch matrix for the fabric edge: NUM_CH channels of CH_W wires each, routed from the south inputs (from_S) to the north outputs (to_N).
- Each channel has a runtime-selectable mode: combinational pass-through, 1-stage registered, 2-stage registered, or tied to zero.
- Mode bits are loaded serially into a shadow register and committed atomically. The commit is length-checked.
- Reset defaults give plain pass-through on every channel, so the block can replace the fixed wire-through terminal tile.

Parameters:
- NUM_CH, 12, number of channels.
- CH_W, 1, width in bits of each channel.
- DEFAULT_MODE, 2'b00, mode loaded into every channel at reset.

Ports:
- UserCLK  input  1  fabric user clock; all flops on the rising edge.
- RESETn  input  1  asynchronous active-low reset.
- from_S  input  NUM_CH*CH_W  south inputs; channel i occupies bits [i*CH_W +: CH_W].
- to_N  output  NUM_CH*CH_W  north outputs, same packing as from_S.
- ConfigData  input  1  serial mode bit.
- ConfigEn  input  1  shift strobe; one bit is shifted in per cycle while high.
- ConfigLatch  input  1  commit strobe, single cycle.
- ConfigErr  output  1  sticky flag: the last commit was rejected.

Interface (already decided):
- One clock, UserCLK. Reset RESETn is asynchronous and active-low.

Behaviour:
- Reset (RESETn=0, asynchronous):
  - shadow register SR (2*NUM_CH bits) = 0, bit counter cnt = 0, ConfigErr = 0.
  - active mode register ACT = DEFAULT_MODE replicated for every channel.
  - all pipeline flops = 0.
- Channel i mode = ACT[2i+1:2i]:
  - 00: to_N channel = from_S channel, combinational, 0 cycles.
  - 01: to_N = stage1 register, 1-cycle latency.
  - 10: to_N = stage2 register, 2-cycle latency.
  - 11: to_N = 0.
- Pipeline:
  - stage1 <= from_S and stage2 <= stage1, every cycle, for all channels, regardless of mode.
  - A mode change therefore takes effect in the cycle after commit, using the current pipeline contents. There is no flush and no bubble insertion.
- Shift path, when ConfigEn=1:
  - SR <= {SR[2N-2:0], ConfigData}, with N = NUM_CH. The last bit shifted in lands in SR[0] and maps to channel 0 bit 0. The first bit shifted maps to channel N-1 bit 1.
  - cnt increments and saturates at 2N+1.
- Counter states, derived from cnt:
  - EMPTY: cnt = 0.
  - LOADING: 0 < cnt < 2N.
  - FULL: cnt = 2N.
  - OVER: cnt = 2N+1, meaning too many bits were shifted.
  - cnt width = clog2(2N+2).
- Commit, when ConfigLatch=1 and ConfigEn=0:
  - In FULL: ACT <= SR, ConfigErr <= 0, cnt <= 0.
  - In EMPTY, LOADING or OVER: ACT unchanged, ConfigErr <= 1, cnt <= 0.
  - SR is never cleared by a commit.
- ConfigEn=1 and ConfigLatch=1 in the same cycle: the shift is performed, the latch is ignored, ConfigErr is unchanged.
- ConfigErr is cleared only by a successful commit or by reset.
- Reset asserted mid-shift: the partial load is discarded and ACT returns to DEFAULT_MODE.
- Reset asserted mid-stream: to_N follows from_S in mode 00 even while in reset; registered modes output 0.

Optional Feature:
- Macro: S_TERM_CFG_READBACK_EN.
- Defined:
  - Adds output port ConfigOut (1 bit) = SR[2N-1], registered as part of SR, for daisy-chaining to the next tile's ConfigData.
  - Adds output port ConfigCnt (cnt width) exposing cnt.
  - Reset value of both ports is 0.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Reset with defaults (NUM_CH=12, CH_W=1), drive from_S=12'hA5C -> to_N=12'hA5C in the same cycle; ConfigErr=0.
- Shift 24 bits so channel 0 = 01 and channel 1 = 10 (all others 00), then pulse ConfigLatch. Toggle from_S[0] and from_S[1] -> to_N[0] lags by 1 cycle, to_N[1] lags by 2 cycles, other bits pass through immediately; ConfigErr=0.
- Shift only 23 bits, then pulse ConfigLatch -> ConfigErr=1 and the mode map is unchanged. Then load 24 bits and commit -> ConfigErr=0 and the new map is applied.
- Shift 25 bits, then pulse ConfigLatch -> ConfigErr=1 (OVER), ACT unchanged, cnt=0 afterwards.
- Load all channels with 11 and commit -> to_N=0 for any from_S. Assert RESETn=0 after 10 further shift bits -> ACT returns to 00, to_N=from_S, cnt=0.
- Raise ConfigEn and ConfigLatch together on bit 24 of a load -> the bit is shifted, no commit, ConfigErr unchanged. A ConfigLatch on the next cycle sees cnt=24 and commits.
